// File: rtl/core_pipe_exec_mdu_ctrl.sv
// Execute-stage sequencer for core_pipe_exec_mdu: issue, hold, capture, re-arm.
// Ports: g_clk/g_resetn, flush, s_* issue side, m_* result side, mdu_* MDU side.
module core_pipe_exec_mdu_ctrl #(
    parameter int unsigned TIMEOUT = 127
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        flush,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_op,
    input  logic        s_op_word,
    input  logic [63:0] s_rs1,
    input  logic [63:0] s_rs2,
    input  logic [4:0]  s_rd_addr,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_rd,
    output logic [4:0]  m_rd_addr,
    output logic        m_err,
    output logic        mdu_valid,
    output logic        mdu_op_word,
    output logic [7:0]  mdu_op,
    output logic [63:0] mdu_rs1,
    output logic [63:0] mdu_rs2,
    output logic        mdu_flush,
    input  logic        mdu_ready,
    input  logic [63:0] mdu_rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CLR,
        S_OUT
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  op_q;
    logic        word_q;
    logic [63:0] rs1_q;
    logic [63:0] rs2_q;
    logic [4:0]  rd_addr_q;
    logic [63:0] rd_q;
    logic        err_q;
    logic [7:0]  cnt_q;

    logic accept;
    logic one_hot;
    logic run;
    logic tmo_hit;

    assign one_hot = (s_op != 8'd0) &&
                     ((s_op & (s_op - 8'd1)) == 8'd0);
    assign s_ready = (state_q == S_IDLE) && !flush;
    assign accept  = s_valid && s_ready;
    assign run     = (state_q == S_RUN);
    // Last permitted RUN cycle; counter starts at 0 on the first.
    assign tmo_hit = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (s_valid) begin
                        state_d = one_hot ? S_RUN : S_OUT;
                    end
                end
                S_RUN: begin
                    if (mdu_ready || tmo_hit) begin
                        state_d = S_CLR;
                    end
                end
                S_CLR: begin
                    state_d = m_ready ? S_IDLE : S_OUT;
                end
                S_OUT: begin
                    if (m_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            op_q      <= 8'd0;
            word_q    <= 1'b0;
            rs1_q     <= 64'd0;
            rs2_q     <= 64'd0;
            rd_addr_q <= 5'd0;
        end else if (accept) begin
            op_q      <= s_op;
            word_q    <= s_op_word;
            rs1_q     <= s_rs1;
            rs2_q     <= s_rs2;
            rd_addr_q <= s_rd_addr;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            rd_q  <= 64'd0;
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else if (accept) begin
            cnt_q <= 8'd0;
            if (!one_hot) begin
                rd_q  <= 64'd0;
                err_q <= 1'b1;
            end
        end else if (run && !flush) begin
            cnt_q <= cnt_q + 8'd1;
            // A result arriving on the timeout cycle is still taken.
            if (mdu_ready) begin
                rd_q  <= mdu_rd;
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                rd_q  <= 64'd0;
                err_q <= 1'b1;
            end
        end
    end

    assign m_valid     = (state_q == S_CLR) || (state_q == S_OUT);
    assign m_rd        = rd_q;
    assign m_rd_addr   = rd_addr_q;
    assign m_err       = err_q;
    assign mdu_valid   = run && !flush;
    assign mdu_op      = run ? op_q : 8'd0;
    assign mdu_op_word = run ? word_q : 1'b0;
    assign mdu_rs1     = rs1_q;
    assign mdu_rs2     = rs2_q;
    // The MDU holds its done state until flushed; CLR re-arms it.
    assign mdu_flush   = flush || (state_q == S_CLR);

endmodule

// File: tb/tb_core_pipe_exec_mdu_ctrl.sv
// Randomized bench for core_pipe_exec_mdu_ctrl with a behavioural MDU stub.
// Expected results come from an arithmetic model of the RISC-V M ops.
module tb_core_pipe_exec_mdu_ctrl;

    localparam int TMO = 8;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_op;
    logic        s_op_word;
    logic [63:0] s_rs1;
    logic [63:0] s_rs2;
    logic [4:0]  s_rd_addr;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_rd;
    logic [4:0]  m_rd_addr;
    logic        m_err;
    logic        mdu_valid;
    logic        mdu_op_word;
    logic [7:0]  mdu_op;
    logic [63:0] mdu_rs1;
    logic [63:0] mdu_rs2;
    logic        mdu_flush;
    logic        mdu_ready;
    logic [63:0] mdu_rd;

    int n_chk  = 0;
    int n_pass = 0;
    int stub_lat = 0;

    always #5 g_clk = ~g_clk;

    core_pipe_exec_mdu_ctrl #(.TIMEOUT(TMO)) dut (
        .g_clk       (g_clk),
        .g_resetn    (g_resetn),
        .flush       (flush),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_op        (s_op),
        .s_op_word   (s_op_word),
        .s_rs1       (s_rs1),
        .s_rs2       (s_rs2),
        .s_rd_addr   (s_rd_addr),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_rd        (m_rd),
        .m_rd_addr   (m_rd_addr),
        .m_err       (m_err),
        .mdu_valid   (mdu_valid),
        .mdu_op_word (mdu_op_word),
        .mdu_op      (mdu_op),
        .mdu_rs1     (mdu_rs1),
        .mdu_rs2     (mdu_rs2),
        .mdu_flush   (mdu_flush),
        .mdu_ready   (mdu_ready),
        .mdu_rd      (mdu_rd)
    );

    function automatic logic [63:0] mdu_model(
        input logic [7:0]  op,
        input logic        w,
        input logic [63:0] a,
        input logic [63:0] b
    );
        logic [127:0] p;
        logic [31:0]  a32;
        logic [31:0]  b32;
        logic [31:0]  r32;
        logic [63:0]  r;
        r32 = 32'd0;
        r   = 64'd0;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            case (op)
                8'h01: r32 = a32 * b32;
                8'h10: begin
                    if (b32 == 0) r32 = '1;
                    else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
                    else r32 = $signed(a32) / $signed(b32);
                end
                8'h20: begin
                    if (b32 == 0) r32 = '1;
                    else r32 = a32 / b32;
                end
                8'h40: begin
                    if (b32 == 0) r32 = a32;
                    else if (a32 == 32'h8000_0000 && b32 == '1) r32 = 0;
                    else r32 = $signed(a32) % $signed(b32);
                end
                8'h80: begin
                    if (b32 == 0) r32 = a32;
                    else r32 = a32 % b32;
                end
                default: r32 = 32'd0;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (op)
                8'h01: r = a * b;
                8'h02: begin
                    p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                    r = p[127:64];
                end
                8'h04: begin
                    p = {64'd0, a} * {64'd0, b};
                    r = p[127:64];
                end
                8'h08: begin
                    p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                    r = p[127:64];
                end
                8'h10: begin
                    if (b == 0) r = '1;
                    else if (a == {1'b1, 63'd0} && b == '1) r = a;
                    else r = $signed(a) / $signed(b);
                end
                8'h20: begin
                    if (b == 0) r = '1;
                    else r = a / b;
                end
                8'h40: begin
                    if (b == 0) r = a;
                    else if (a == {1'b1, 63'd0} && b == '1) r = 0;
                    else r = $signed(a) % $signed(b);
                end
                8'h80: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
                default: r = 64'd0;
            endcase
        end
        return r;
    endfunction

    // MDU stub: done persists until mdu_flush, like the real unit.
    int   stub_cnt;
    logic stub_done;
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
            mdu_rd    <= 64'd0;
        end else if (mdu_flush) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else if (mdu_valid && !stub_done) begin
            if (stub_cnt == stub_lat) begin
                stub_done <= 1'b1;
                mdu_rd    <= mdu_model(mdu_op, mdu_op_word, mdu_rs1, mdu_rs2);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end
    assign mdu_ready = stub_done;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_op(input logic [7:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, input int lat, input int bp);
        logic        legal;
        int          exp_runs;
        logic        exp_err;
        logic [63:0] exp_rd;
        int          runs;
        logic        stable;
        logic        done;
        logic [63:0] hold_rd;
        logic        hold_ok;
        legal = ($countones(op) == 1);
        if (!legal) begin
            exp_runs = 0; exp_err = 1'b1; exp_rd = 64'd0;
        end else if (lat + 2 <= TMO) begin
            exp_runs = lat + 2; exp_err = 1'b0;
            exp_rd = mdu_model(op, w, a, b);
        end else begin
            exp_runs = TMO; exp_err = 1'b1; exp_rd = 64'd0;
        end
        stub_lat = lat;
        @(negedge g_clk);
        chk("s_ready_idle", s_ready, 1);
        s_valid = 1'b1; s_op = op; s_op_word = w;
        s_rs1 = a; s_rs2 = b; s_rd_addr = rd;
        @(posedge g_clk);
        #1;
        s_valid = 1'b0; s_op = 8'($urandom); s_op_word = 1'($urandom);
        s_rs1 = {$urandom, $urandom}; s_rs2 = {$urandom, $urandom};
        s_rd_addr = 5'($urandom);
        runs = 0; stable = 1'b1; done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge g_clk);
            if (mdu_valid) begin
                runs++;
                if (mdu_op !== op || mdu_op_word !== w ||
                    mdu_rs1 !== a || mdu_rs2 !== b) stable = 1'b0;
            end else if (m_valid) begin
                done = 1'b1;
            end
        end
        chk("m_valid_seen", done, 1);
        chk("run_cycles", runs, exp_runs);
        chk("m_rd", m_rd, exp_rd);
        chk("m_err", m_err, exp_err);
        chk("m_rd_addr", m_rd_addr, rd);
        chk("mdu_flush_pulse", mdu_flush, legal);
        chk("mdu_op_outside_run", mdu_op, 0);
        chk("mdu_in_stable", stable, 1);
        hold_rd = m_rd; hold_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            @(negedge g_clk);
            if (!m_valid || m_rd !== hold_rd || s_ready || mdu_flush)
                hold_ok = 1'b0;
        end
        chk("backpressure_hold", hold_ok, 1);
        m_ready = 1'b1;
        @(posedge g_clk);
        #1;
        m_ready = 1'b0;
        @(negedge g_clk);
        chk("idle_after_hs", {m_valid, s_ready, mdu_flush}, 3'b010);
    endtask

    task automatic flush_mid(input int n);
        stub_lat = 255;
        @(negedge g_clk);
        s_valid = 1'b1; s_op = 8'h20; s_op_word = 1'b0;
        s_rs1 = 64'd100; s_rs2 = 64'd7; s_rd_addr = 5'd9;
        @(posedge g_clk);
        #1;
        s_valid = 1'b0;
        for (int i = 0; i < n; i++) @(negedge g_clk);
        chk("run_before_flush", mdu_valid, 1);
        flush = 1'b1;
        #1;
        chk("flush_mdu_flush", mdu_flush, 1);
        chk("flush_mdu_valid", mdu_valid, 0);
        @(posedge g_clk);
        #1;
        flush = 1'b0;
        @(negedge g_clk);
        chk("after_flush", {m_valid, s_ready, mdu_valid}, 3'b010);
    endtask

    function automatic logic [63:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return {1'b1, 63'd0};
            3: return 64'($urandom_range(0, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [7:0] op;
        logic       w;
        g_resetn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_op = 8'd0;
        s_op_word = 1'b0; s_rs1 = 64'd0; s_rs2 = 64'd0; s_rd_addr = 5'd0;
        m_ready = 1'b0;
        #12;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_outs", {m_valid, m_err, mdu_valid, mdu_op_word, mdu_flush},
            5'b0);
        chk("rst_data", m_rd | mdu_rs1 | mdu_rs2 | {mdu_op, m_rd_addr}, 0);
        flush = 1'b1;
        #1;
        chk("rst_flush_pass", mdu_flush, 1);
        flush = 1'b0;
        @(negedge g_clk);
        g_resetn = 1'b1;

        do_op(8'h01, 1'b0, 64'd7, 64'd6, 5'd3, 1, 0);
        do_op(8'h10, 1'b1, 64'hFFFF_FFEC, 64'd3, 5'd4, 3, 0);
        do_op(8'h04, 1'b0, '1, '1, 5'd5, 2, 5);
        do_op(8'h20, 1'b0, 64'd50, 64'd0, 5'd6, 255, 2);
        do_op(8'h01, 1'b0, 64'd2, 64'd2, 5'd7, TMO - 2, 0);
        do_op(8'h01, 1'b0, 64'd2, 64'd2, 5'd7, TMO - 1, 1);
        do_op(8'h03, 1'b0, 64'd1, 64'd1, 5'd8, 0, 0);
        do_op(8'h00, 1'b0, 64'd1, 64'd1, 5'd9, 0, 3);

        flush_mid(5);
        do_op(8'h01, 1'b0, 64'd3, 64'd5, 5'd10, 0, 0);

        @(negedge g_clk);
        s_valid = 1'b1; s_op = 8'h01; flush = 1'b1;
        #1;
        chk("flush_blocks_accept", s_ready, 0);
        @(posedge g_clk);
        #1;
        s_valid = 1'b0; flush = 1'b0;
        @(negedge g_clk);
        chk("no_accept_on_flush", {mdu_valid, m_valid, s_ready}, 3'b001);

        stub_lat = 255;
        @(negedge g_clk);
        s_valid = 1'b1; s_op = 8'h02;
        @(posedge g_clk);
        #1;
        s_valid = 1'b0;
        repeat (3) @(negedge g_clk);
        #2;
        g_resetn = 1'b0;
        #1;
        chk("async_rst", {s_ready, mdu_valid, m_valid}, 3'b100);
        @(negedge g_clk);
        g_resetn = 1'b1;

        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 5) == 0)
                op = ($urandom_range(0, 1) == 1) ? 8'h00
                     : 8'(8'h03 << $urandom_range(0, 6));
            else
                op = 8'(1 << $urandom_range(0, 7));
            w = (op == 8'h01 || op[7:4] != 0) ? 1'($urandom) : 1'b0;
            do_op(op, w, rnd_val(), rnd_val(), 5'($urandom),
                  $urandom_range(0, TMO), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
